// File: rtl/fp16_rowmax_feeder.sv
// Buffers one row of FP16 logits, finds the row maximum, then replays each element on `a` with the max on `b`.
// Optional row_max/row_max_valid side outputs are enabled by defining FP16_FEEDER_MAX_OUT_EN.
module fp16_rowmax_feeder #(
  parameter int ROW_LEN = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [15:0] a,
  output logic        a_valid,
  input  logic        a_ready,
  output logic [15:0] b,
  output logic        b_valid,
  input  logic        b_ready,
  output logic        row_done
`ifdef FP16_FEEDER_MAX_OUT_EN
  ,
  output logic [15:0] row_max,
  output logic        row_max_valid
`endif
);

  localparam int              IDX_W     = (ROW_LEN > 1) ? $clog2(ROW_LEN) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ROW_LEN - 1);
  localparam logic [0:0]      ST_LOAD   = 1'b0;
  localparam logic [0:0]      ST_REPLAY = 1'b1;
  localparam logic [15:0]     CANON_NAN = 16'h7E00;

  // Maps FP16 bit patterns onto an unsigned scale that follows numeric order (+0 above -0).
  function automatic logic [15:0] order_key(input logic [15:0] x);
    return x[15] ? ~x : (x | 16'h8000);
  endfunction

  logic [15:0]      row_buf_q [ROW_LEN];
  logic [0:0]       state_q, state_d;
  logic [IDX_W-1:0] wr_idx_q, wr_idx_d;
  logic [IDX_W-1:0] rd_idx_q, rd_idx_d;
  logic [15:0]      max_q, max_d;
  logic             nan_q, nan_d;
  logic [15:0]      a_q, a_d;
  logic [15:0]      b_q, b_d;
  logic             a_valid_q, a_valid_d;
  logic             b_valid_q, b_valid_d;
  logic             a_done_q, a_done_d;
  logic             b_done_q, b_done_d;
  logic             row_done_q, row_done_d;
`ifdef FP16_FEEDER_MAX_OUT_EN
  logic [15:0]      row_max_q, row_max_d;
  logic             row_max_valid_q, row_max_valid_d;
`endif

  logic             in_xfer;
  logic             in_is_nan;
  logic             in_wins;
  logic             a_done_now;
  logic             b_done_now;
  logic [IDX_W-1:0] rd_idx_next;

  assign in_ready    = (state_q == ST_LOAD);
  assign in_xfer     = in_ready & in_valid;
  assign in_is_nan   = (in_data[14:10] == 5'h1F) && (in_data[9:0] != 10'd0);
  assign in_wins     = (wr_idx_q == '0) || (order_key(in_data) > order_key(max_q));
  assign a_done_now  = a_done_q | (a_valid_q & a_ready);
  assign b_done_now  = b_done_q | (b_valid_q & b_ready);
  assign rd_idx_next = rd_idx_q + IDX_W'(1);

  always_comb begin
    state_d    = state_q;
    wr_idx_d   = wr_idx_q;
    rd_idx_d   = rd_idx_q;
    max_d      = max_q;
    nan_d      = nan_q;
    a_d        = a_q;
    b_d        = b_q;
    a_valid_d  = a_valid_q;
    b_valid_d  = b_valid_q;
    a_done_d   = a_done_q;
    b_done_d   = b_done_q;
    row_done_d = 1'b0;
`ifdef FP16_FEEDER_MAX_OUT_EN
    row_max_d       = row_max_q;
    row_max_valid_d = 1'b0;
`endif
    if (state_q == ST_LOAD) begin
      if (in_xfer) begin
        wr_idx_d = wr_idx_q + IDX_W'(1);
        if (in_wins) max_d = in_data;
        nan_d = (wr_idx_q == '0) ? in_is_nan : (nan_q | in_is_nan);
        if (wr_idx_q == LAST_IDX) begin
          // Element 0 is already in the buffer, so the first replay word is loaded on the final write.
          wr_idx_d  = '0;
          state_d   = ST_REPLAY;
          a_d       = row_buf_q[rd_idx_q];
          b_d       = nan_d ? CANON_NAN : max_d;
          a_valid_d = 1'b1;
          b_valid_d = 1'b1;
`ifdef FP16_FEEDER_MAX_OUT_EN
          row_max_d       = nan_d ? CANON_NAN : max_d;
          row_max_valid_d = 1'b1;
`endif
        end
      end
    end else begin
      if (a_done_now && b_done_now) begin
        a_done_d = 1'b0;
        b_done_d = 1'b0;
        if (rd_idx_q == LAST_IDX) begin
          rd_idx_d   = '0;
          state_d    = ST_LOAD;
          row_done_d = 1'b1;
          a_valid_d  = 1'b0;
          b_valid_d  = 1'b0;
        end else begin
          rd_idx_d  = rd_idx_next;
          a_d       = row_buf_q[rd_idx_next];
          a_valid_d = 1'b1;
          b_valid_d = 1'b1;
        end
      end else begin
        // Channels finish independently; each drops valid after its own transfer.
        a_done_d  = a_done_now;
        b_done_d  = b_done_now;
        a_valid_d = a_valid_q & ~a_ready;
        b_valid_d = b_valid_q & ~b_ready;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (in_xfer) row_buf_q[wr_idx_q] <= in_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_LOAD;
      wr_idx_q   <= '0;
      rd_idx_q   <= '0;
      max_q      <= '0;
      nan_q      <= 1'b0;
      a_q        <= '0;
      b_q        <= '0;
      a_valid_q  <= 1'b0;
      b_valid_q  <= 1'b0;
      a_done_q   <= 1'b0;
      b_done_q   <= 1'b0;
      row_done_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_idx_q   <= wr_idx_d;
      rd_idx_q   <= rd_idx_d;
      max_q      <= max_d;
      nan_q      <= nan_d;
      a_q        <= a_d;
      b_q        <= b_d;
      a_valid_q  <= a_valid_d;
      b_valid_q  <= b_valid_d;
      a_done_q   <= a_done_d;
      b_done_q   <= b_done_d;
      row_done_q <= row_done_d;
    end
  end

`ifdef FP16_FEEDER_MAX_OUT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_max_q       <= '0;
      row_max_valid_q <= 1'b0;
    end else begin
      row_max_q       <= row_max_d;
      row_max_valid_q <= row_max_valid_d;
    end
  end

  assign row_max       = row_max_q;
  assign row_max_valid = row_max_valid_q;
`endif

  assign a        = a_q;
  assign b        = b_q;
  assign a_valid  = a_valid_q;
  assign b_valid  = b_valid_q;
  assign row_done = row_done_q;

endmodule

// File: tb/tb_fp16_rowmax_feeder.sv
// Bench for fp16_rowmax_feeder (ROW_LEN=4): table rows, scripted backpressure/reset cases, random rows vs a real-valued max model.
module tb_fp16_rowmax_feeder;
  localparam int N = 4;
  typedef logic [15:0] row_t [N];
  typedef struct {
    row_t        v;
    logic [15:0] exp_b;
    int          mode;
    bit          garbage;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] in_data = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] a;
  logic        a_valid;
  logic        a_ready = 1'b1;
  logic [15:0] b;
  logic        b_valid;
  logic        b_ready = 1'b1;
  logic        row_done;
`ifdef FP16_FEEDER_MAX_OUT_EN
  logic [15:0] row_max;
  logic        row_max_valid;
`endif

  fp16_rowmax_feeder #(.ROW_LEN(N)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .a_valid(a_valid), .a_ready(a_ready),
    .b(b), .b_valid(b_valid), .b_ready(b_ready),
    .row_done(row_done)
`ifdef FP16_FEEDER_MAX_OUT_EN
    , .row_max(row_max), .row_max_valid(row_max_valid)
`endif
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  logic [15:0] qa[$];
  logic [15:0] qb[$];
  int rd_cnt, in_cnt, overlap_err, stable_err, rmv_cnt, rmv_bad;
  logic [15:0] rm_val;
  logic pa_stall, pb_stall;
  logic [15:0] pa, pb;
  vec_t tbl[$];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  // Reference: numeric value of an FP16 pattern (infinity mapped beyond the finite range).
  function automatic real fval(input logic [15:0] x);
    int e, m, sc;
    real r;
    e = int'(x[14:10]);
    m = int'(x[9:0]);
    if (e == 31) r = 1.0e12;
    else begin
      if (e == 0) begin r = m; sc = -24; end
      else begin r = 1024 + m; sc = e - 25; end
      while (sc > 0) begin r = r * 2.0; sc--; end
      while (sc < 0) begin r = r / 2.0; sc++; end
    end
    return x[15] ? -r : r;
  endfunction

  function automatic bit is_nan(input logic [15:0] x);
    return (x[14:10] == 5'h1F) && (x[9:0] != 10'd0);
  endfunction

  function automatic logic [15:0] model_max(input row_t v);
    logic [15:0] best;
    for (int i = 0; i < N; i++) if (is_nan(v[i])) return 16'h7E00;
    best = v[0];
    for (int i = 1; i < N; i++)
      if (fval(v[i]) > fval(best) || (fval(v[i]) == fval(best) && v[i] == 16'h0000 && best == 16'h8000))
        best = v[i];
    return best;
  endfunction

  task automatic cycle();
    @(negedge clk);
    if (pa_stall && !(a_valid && a == pa)) stable_err++;
    if (pb_stall && !(b_valid && b == pb)) stable_err++;
    pa_stall = a_valid && !a_ready; pa = a;
    pb_stall = b_valid && !b_ready; pb = b;
    if (a_valid && a_ready) qa.push_back(a);
    if (b_valid && b_ready) qb.push_back(b);
    if (row_done) rd_cnt++;
    if (in_valid && in_ready) in_cnt++;
    if (in_ready && (a_valid || b_valid)) overlap_err++;
`ifdef FP16_FEEDER_MAX_OUT_EN
    if (row_max_valid) begin
      rmv_cnt++;
      rm_val = row_max;
      if (!a_valid) rmv_bad++;
    end
`endif
    @(posedge clk);
    #1;
  endtask

  task automatic clear_mon();
    qa.delete(); qb.delete();
    rd_cnt = 0; in_cnt = 0; overlap_err = 0; stable_err = 0;
    rmv_cnt = 0; rmv_bad = 0; rm_val = '0; pa_stall = 0; pb_stall = 0;
  endtask

  task automatic feed(input string tag, input row_t v);
    int k;
    a_ready = 1'b1; b_ready = 1'b1;
    for (int i = 0; i < N; i++) begin
      in_valid = 1'b1; in_data = v[i]; k = 0;
      do begin cycle(); k++; end while (in_cnt == i && k < 50);
      if (k >= 50) chk($sformatf("%s feed_timeout", tag), 32'(in_cnt), 32'(i + 1));
    end
    in_valid = 1'b0;
  endtask

  task automatic run_row(input string tag, input row_t v, input logic [15:0] exp_b, input int mode, input bit garbage);
    int k, blow;
    clear_mon();
    feed(tag, v);
    in_valid = garbage; in_data = 16'h5A5A;
    chk($sformatf("%s first_valid", tag), {30'd0, a_valid, b_valid}, 32'd3);
    k = 0; blow = 0;
    while ((qa.size() < N || qb.size() < N) && k < 200) begin
      case (mode)
        0: begin a_ready = 1'b1; b_ready = 1'b1; end
        1: begin a_ready = 1'($urandom_range(0, 1)); b_ready = 1'($urandom_range(0, 1)); end
        default: begin
          a_ready = (k % 4 == 0) || (k % 4 == 3);
          if (qb.size() == 2 && blow < 3) begin b_ready = 1'b0; blow++; end
          else b_ready = 1'b1;
        end
      endcase
      cycle();
      k++;
    end
    in_valid = 1'b0; a_ready = 1'b1; b_ready = 1'b1;
    if (k >= 200) chk($sformatf("%s replay_timeout", tag), 32'(k), 32'd0);
    if (mode == 0) chk($sformatf("%s replay_cycles", tag), 32'(k), 32'(N));
    chk($sformatf("%s in_ready_after", tag), {31'd0, in_ready}, 32'd1);
    cycle();
    cycle();
    chk($sformatf("%s a_count", tag), 32'(qa.size()), 32'(N));
    chk($sformatf("%s b_count", tag), 32'(qb.size()), 32'(N));
    for (int i = 0; i < N; i++) begin
      chk($sformatf("%s a[%0d]", tag, i), (qa.size() > i) ? {16'd0, qa[i]} : 32'hDEAD_0000, {16'd0, v[i]});
      chk($sformatf("%s b[%0d]", tag, i), (qb.size() > i) ? {16'd0, qb[i]} : 32'hDEAD_0000, {16'd0, exp_b});
    end
    chk($sformatf("%s row_done_pulses", tag), 32'(rd_cnt), 32'd1);
    chk($sformatf("%s inputs_accepted", tag), 32'(in_cnt), 32'(N));
    chk($sformatf("%s in_ready_during_replay", tag), 32'(overlap_err), 32'd0);
    chk($sformatf("%s stall_stability", tag), 32'(stable_err), 32'd0);
`ifdef FP16_FEEDER_MAX_OUT_EN
    chk($sformatf("%s row_max_pulses", tag), 32'(rmv_cnt), 32'd1);
    chk($sformatf("%s row_max_align", tag), 32'(rmv_bad), 32'd0);
    chk($sformatf("%s row_max", tag), {16'd0, rm_val}, {16'd0, exp_b});
    chk($sformatf("%s row_max_hold", tag), {16'd0, row_max}, {16'd0, exp_b});
`endif
  endtask

  task automatic add(input logic [15:0] v0, v1, v2, v3, input logic [15:0] eb, input int mode, input bit garb);
    vec_t t;
    t.v = '{v0, v1, v2, v3};
    t.exp_b = eb; t.mode = mode; t.garbage = garb;
    tbl.push_back(t);
  endtask

  initial begin
    row_t r;
    logic [15:0] specials [10];
    specials = '{16'h0000, 16'h8000, 16'h7C00, 16'hFC00, 16'h0001,
                 16'h8001, 16'h03FF, 16'h7BFF, 16'hFBFF, 16'h83FF};

    add(16'h3C00, 16'hC000, 16'h4200, 16'h0000, 16'h4200, 0, 0);
    add(16'hBC00, 16'hC000, 16'hC200, 16'hC400, 16'hBC00, 0, 0);
    add(16'h8000, 16'h0000, 16'h8000, 16'h8000, 16'h0000, 0, 0);
    add(16'h3C00, 16'h7E01, 16'h4000, 16'hFC00, 16'h7E00, 0, 0);
    add(16'h3C00, 16'h4000, 16'h4200, 16'h4400, 16'h4400, 2, 1);
    add(16'h0001, 16'h8001, 16'h0000, 16'h0002, 16'h0002, 1, 0);
    add(16'h7C00, 16'h7BFF, 16'hFC00, 16'h0000, 16'h7C00, 1, 1);
    add(16'hFC00, 16'hFBFF, 16'h8400, 16'h8001, 16'h8001, 0, 0);

    clear_mon();
    repeat (2) @(posedge clk);
    #1;
    chk("reset in_ready", {31'd0, in_ready}, 32'd1);
    chk("reset valids", {30'd0, a_valid, b_valid}, 32'd0);
    chk("reset data", {a, b}, 32'd0);
    chk("reset row_done", {31'd0, row_done}, 32'd0);
    rst_n = 1'b1;
    #2;

    foreach (tbl[i]) run_row($sformatf("tbl%0d", i), tbl[i].v, tbl[i].exp_b, tbl[i].mode, tbl[i].garbage);

    // Reset in the middle of replay.
    clear_mon();
    r = '{16'h4000, 16'h4200, 16'h4400, 16'h4600};
    feed("midrst", r);
    cycle();
    cycle();
    chk("midrst a_sent", 32'(qa.size()), 32'd2);
    rst_n = 1'b0;
    #1;
    chk("midrst valids", {30'd0, a_valid, b_valid}, 32'd0);
    chk("midrst in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    #1;
    chk("midrst held", {29'd0, a_valid, b_valid, row_done}, 32'd0);
    rst_n = 1'b1;
    #2;
    run_row("post_reset", '{16'h4400, 16'h4400, 16'h4400, 16'h4400}, 16'h4400, 0, 0);

    for (int n = 0; n < 16; n++) begin
      for (int i = 0; i < N; i++) begin
        case ($urandom_range(0, 9))
          0, 1, 2: r[i] = specials[$urandom_range(0, 9)];
          3: r[i] = (n % 4 == 0) ? {1'($urandom_range(0, 1)), 5'h1F, 10'($urandom_range(1, 1023))} : 16'($urandom());
          default: r[i] = 16'($urandom());
        endcase
      end
      run_row($sformatf("rnd%0d", n), r, model_max(r), 1, n[0]);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
